// File: rtl/cartesiantopolar_seq.sv
// Sequenced Cartesian-to-polar converter: one iterative CORDIC vectoring datapath
// shared across requests, valid/ready handshake on input and output.
module cartesiantopolar_seq #(
  parameter int unsigned ITER = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] x,
  input  logic signed [7:0] y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        r1,
  output logic signed [7:0] theta1,
  output logic              busy
);

  // Six fraction bits keep small vectors (e.g. |v| = 4) accurate to one output LSB;
  // worst case 181 * 1.647 * 64 stays below 2^15.
  localparam int unsigned FRAC = 6;
  localparam int unsigned DW   = 16;
  localparam int unsigned ZW   = 12;
  localparam int unsigned IW   = 3;
  localparam int unsigned PW   = 32;
  localparam int unsigned GAIN = 155;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLD,
    S_ROT,
    S_SCALE,
    S_DONE
  } state_t;

  state_t               r_state;
  logic signed [DW-1:0] r_x;
  logic signed [DW-1:0] r_y;
  logic signed [ZW-1:0] r_z;
  logic [IW-1:0]        r_iter;
  logic                 r_zero;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [7:0]           r_r1;
  logic signed [7:0]    r_theta1;

  logic signed [DW-1:0] w_xs;
  logic signed [DW-1:0] w_ys;
  logic signed [ZW-1:0] w_atan;
  logic signed [ZW-1:0] w_zr;
  logic [PW-1:0]        w_prod;
  logic [PW-1:0]        w_mag;
  logic                 w_last;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign r1        = r_r1;
  assign theta1    = r_theta1;

  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;
  assign w_last = (r_iter == IW'(ITER - 1));

  // Magnitude: x * 155/256 removes the CORDIC gain, then drop fraction bits with rounding.
  assign w_prod = PW'($unsigned(r_x)) * PW'(GAIN) + (PW'(1) << (FRAC + 7));
  assign w_mag  = w_prod >> (FRAC + 8);
  assign w_zr   = r_z + 12'sd8;

  // atan(2^-i) in units of pi/2048
  always_comb begin
    w_atan = 12'sd0;
    case (r_iter)
      3'd0:    w_atan = 12'sd512;
      3'd1:    w_atan = 12'sd302;
      3'd2:    w_atan = 12'sd160;
      3'd3:    w_atan = 12'sd81;
      3'd4:    w_atan = 12'sd41;
      3'd5:    w_atan = 12'sd20;
      3'd6:    w_atan = 12'sd10;
      3'd7:    w_atan = 12'sd5;
      default: w_atan = 12'sd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_iter      <= '0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_r1        <= '0;
      r_theta1    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x        <= DW'(x) <<< FRAC;
            r_y        <= DW'(y) <<< FRAC;
            r_zero     <= (x == 8'sd0) && (y == 8'sd0);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_FOLD;
          end
        end
        S_FOLD: begin
          // Left half-plane: rotate by pi; +pi and -pi alias to the same 12b code.
          if (r_x < 0) begin
            r_x <= -r_x;
            r_y <= -r_y;
            r_z <= 12'sh800;
          end else begin
            r_z <= '0;
          end
          r_iter  <= '0;
          r_state <= S_ROT;
        end
        S_ROT: begin
          if (r_y[DW-1]) begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end else begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end
          r_iter <= r_iter + 3'd1;
          if (w_last) begin
            r_state <= S_SCALE;
          end
        end
        S_SCALE: begin
          if (r_zero) begin
            r_r1     <= '0;
            r_theta1 <= '0;
          end else begin
            r_r1     <= (w_mag > PW'(255)) ? 8'hFF : 8'(w_mag);
            r_theta1 <= 8'(w_zr >>> 4);
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cartesiantopolar_seq.sv
// Directed-vector bench for cartesiantopolar_seq: expected magnitudes/angles are
// hand-computed ideals, accepted within +/-1 LSB (angle compared modulo 256).
module tb_cartesiantopolar_seq;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x;
  logic signed [7:0] y;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        r1;
  logic signed [7:0] theta1;
  logic              busy;

  int n_vec;
  int n_err;

  cartesiantopolar_seq #(.ITER(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r1        (r1),
    .theta1    (theta1),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait for its result; leaves the result handshaken.
  task automatic run_conv(input logic signed [7:0] ix, input logic signed [7:0] iy,
                          output logic [7:0] ro, output logic signed [7:0] to,
                          output int lat);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    x = ix; y = iy; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = 8'sh55; y = -8'sd77;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    ro = r1; to = theta1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++; $display("FAIL reset_flags: got ir/ov/busy=%b, want 100", {in_ready, out_valid, busy});
    end
    n_vec++;
    if (r1 !== 8'd0 || theta1 !== 8'sd0) begin
      n_err++; $display("FAIL reset_data: got r1=%0d theta1=%0d, want 0 0", r1, theta1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    logic signed [7:0] dt;
    out_ready = 1'b1;
    x = 8'sd3; y = 8'sd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = -8'sd100; y = 8'sd90;
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_busy: got busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    n_vec++;
    if (lat != 10) begin
      n_err++; $display("FAIL basic_latency: got %0d edges, want 10", lat);
    end
    n_vec++;
    if (int'(r1) < 4 || int'(r1) > 6) begin
      n_err++; $display("FAIL basic_r1: got %0d, want 5+/-1", r1);
    end
    dt = theta1 - 8'sd38;
    n_vec++;
    if (dt > 8'sd1 || dt < -8'sd1) begin
      n_err++; $display("FAIL basic_theta1: got %0d, want 38+/-1", theta1);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_err++; $display("FAIL basic_release: got ov/ir/busy=%b, want 010", {out_valid, in_ready, busy});
    end
    n_vec++;
    if (int'(r1) < 4 || int'(r1) > 6) begin
      n_err++; $display("FAIL basic_hold: got r1=%0d after handshake, want 5+/-1", r1);
    end
  endtask

  task automatic test_vectors(input string name, input int cnt, input int tx[4], input int ty[4],
                              input int er[4], input int et[4]);
    logic [7:0]        ro;
    logic signed [7:0] to;
    logic signed [7:0] dt;
    int                lat;
    for (int k = 0; k < cnt; k++) begin
      run_conv(8'(tx[k]), 8'(ty[k]), ro, to, lat);
      n_vec++;
      if (lat != 10) begin
        n_err++; $display("FAIL %s_lat(%0d,%0d): got %0d, want 10", name, tx[k], ty[k], lat);
      end
      n_vec++;
      if (int'(ro) < er[k] - 1 || int'(ro) > er[k] + 1) begin
        n_err++; $display("FAIL %s_r1(%0d,%0d): got %0d, want %0d+/-1", name, tx[k], ty[k], ro, er[k]);
      end
      dt = to - 8'(et[k]);
      n_vec++;
      if (dt > 8'sd1 || dt < -8'sd1) begin
        n_err++; $display("FAIL %s_theta1(%0d,%0d): got %0d, want %0d+/-1", name, tx[k], ty[k], to, et[k]);
      end
    end
  endtask

  task automatic test_quadrants;
    test_vectors("quad", 4, '{-12, -4, 123, 0}, '{-5, 0, -45, 0}, '{13, 4, 131, 0}, '{-112, -128, -14, 0});
  endtask

  task automatic test_extremes;
    test_vectors("ext", 2, '{-128, 127, 0, 0}, '{-128, 0, 0, 0}, '{181, 127, 0, 0}, '{-96, 0, 0, 0});
  endtask

  task automatic test_back_to_back;
    test_vectors("b2b", 3, '{5, 0, -100, 0}, '{12, -7, 100, 0}, '{13, 7, 141, 0}, '{48, -64, 96, 0});
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    logic signed [7:0] dt;
    x = 8'sd5; y = 8'sd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    n_vec++;
    if (lat != 10) begin
      n_err++; $display("FAIL bp_latency: got %0d, want 10", lat);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0]; x = 8'(c * 7 - 60); y = 8'(40 - c * 3);
      @(posedge clk); #1;
      dt = theta1 - 8'sd48;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || r1 !== 8'd13 && r1 !== 8'd12 && r1 !== 8'd14
          || dt > 8'sd1 || dt < -8'sd1) begin
        n_err++; bad++;
        if (bad < 4)
          $display("FAIL bp_hold[%0d]: got ov=%b ir=%b r1=%0d theta1=%0d, want 1 0 13+/-1 48+/-1",
                   c, out_valid, in_ready, r1, theta1);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_no_phantom: got busy=%b ov=%b ir=%b, want 0 0 1", busy, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_rot;
    logic [7:0]        ro;
    logic signed [7:0] to;
    logic signed [7:0] dt;
    int                lat;
    int                seen;
    x = 8'sd100; y = 8'sd50; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_vec++;
    if ({in_ready, out_valid, busy} !== 3'b100 || r1 !== 8'd0 || theta1 !== 8'sd0) begin
      n_err++; $display("FAIL rst_rot_state: got ir/ov/busy=%b r1=%0d theta1=%0d, want 100 0 0",
                        {in_ready, out_valid, busy}, r1, theta1);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL rst_rot_abort: got %0d active cycles, want 0", seen);
    end
    run_conv(8'sd6, 8'sd8, ro, to, lat);
    n_vec++;
    if (lat != 10 || int'(ro) < 9 || int'(ro) > 11) begin
      n_err++; $display("FAIL rst_rot_r1: got r1=%0d lat=%0d, want 10+/-1 lat 10", ro, lat);
    end
    dt = to - 8'sd38;
    n_vec++;
    if (dt > 8'sd1 || dt < -8'sd1) begin
      n_err++; $display("FAIL rst_rot_theta1: got %0d, want 38+/-1", to);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_quadrants();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_rot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
